// File: rtl/microwave_countdown_timer.sv
// ---------------------------------------------------------------------------
// microwave_countdown_timer
//
// Four-digit BCD MM:SS countdown register for the microwave controller.
// Digits from the keypad encoder are shifted in from the right, one per key
// press, in the usual microwave style. While the countdown is enabled, the
// time counts down once per rising edge of the encoder's 1 Hz pulse train.
//
// Optional feature macro: MICROWAVE_DONE_PULSE_EN
//   When defined, the block gains a 'done' output. It pulses high for one
//   clk cycle after a running countdown expires.
//
// Parameters:
//   SYNC_STAGES    flops synchronising pgt_1Hz into clk domain (2..3)
//   SEC_TENS_WRAP  value loaded into sec_tens on a borrow from minutes
//
// Ports:
//   clk       in   system clock
//   clearn    in   asynchronous active-low reset
//   D         in   BCD digit from encoder (values above 9 are ignored)
//   loadn     in   active-low digit strobe, held low while a key is held
//   pgt_1Hz   in   1 Hz pulse train, asynchronous to clk
//   enablen   in   0 = run countdown, 1 = entry / pause
//   sec_ones  out  BCD seconds units
//   sec_tens  out  BCD seconds tens
//   min_ones  out  BCD minutes units
//   min_tens  out  BCD minutes tens
//   zero      out  all four digits are 0
//   counting  out  FSM is in RUN
//   done      out  (MICROWAVE_DONE_PULSE_EN only) expiry pulse
// ---------------------------------------------------------------------------
module microwave_countdown_timer #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [3:0] SEC_TENS_WRAP = 4'd5
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       enablen,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       zero,
    output logic       counting
`ifdef MICROWAVE_DONE_PULSE_EN
    ,
    output logic       done
`endif
);

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic                   loadn_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_prev;
    logic                   load_event;
    logic                   load_ok;
    logic                   tick;

    // Digit values after a (possible) shift-in, and after one decrement
    logic [3:0] ld_sec_ones, ld_sec_tens, ld_min_ones, ld_min_tens;
    logic [3:0] dec_sec_ones, dec_sec_tens, dec_min_ones, dec_min_tens;
    logic       ld_zero;
    logic       dec_zero;

`ifdef MICROWAVE_DONE_PULSE_EN
    logic done_arm;
`endif

    // One load event per key press: the strobe's falling edge only
    assign load_event = ~loadn & loadn_q;
    assign load_ok    = load_event && (D <= 4'd9);

    // Rising edge of the synchronised 1 Hz train
    assign tick = sync_q[SYNC_STAGES-1] & ~tick_prev;

    assign zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                  (min_ones == 4'd0) && (min_tens == 4'd0);

    // Candidate values for a digit shift-in. The ENTRY->RUN decision looks
    // at the post-load value, so a key press landing in the same cycle as
    // enablen falling still starts the run with the new time.
    always_comb begin
        ld_sec_ones = sec_ones;
        ld_sec_tens = sec_tens;
        ld_min_ones = min_ones;
        ld_min_tens = min_tens;
        if (load_ok) begin
            ld_min_tens = min_ones;
            ld_min_ones = sec_tens;
            ld_sec_tens = sec_ones;
            ld_sec_ones = D;
        end
        ld_zero = (ld_sec_ones == 4'd0) && (ld_sec_tens == 4'd0) &&
                  (ld_min_ones == 4'd0) && (ld_min_tens == 4'd0);
    end

    // BCD borrow chain for a one-second decrement. Seconds tens wrap to
    // SEC_TENS_WRAP rather than 9, but entered values above 59 still count
    // straight down since the borrow only happens at a tens digit of 0.
    always_comb begin
        dec_sec_ones = sec_ones;
        dec_sec_tens = sec_tens;
        dec_min_ones = min_ones;
        dec_min_tens = min_tens;
        if (sec_ones != 4'd0) begin
            dec_sec_ones = sec_ones - 4'd1;
        end else begin
            dec_sec_ones = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_sec_tens = sec_tens - 4'd1;
            end else begin
                dec_sec_tens = SEC_TENS_WRAP;
                if (min_ones != 4'd0) begin
                    dec_min_ones = min_ones - 4'd1;
                end else begin
                    dec_min_ones = 4'd9;
                    dec_min_tens = min_tens - 4'd1;
                end
            end
        end
        dec_zero = (dec_sec_ones == 4'd0) && (dec_sec_tens == 4'd0) &&
                   (dec_min_ones == 4'd0) && (dec_min_tens == 4'd0);
    end

    // Input conditioning, FSM, digit registers and registered status
    // outputs. A tick that coincides with enablen rising is dropped in
    // favour of the pause; RUN is never entered at 00:00, so the decrement
    // can never underflow.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state     <= ENTRY;
            loadn_q   <= 1'b1;
            sync_q    <= '0;
            tick_prev <= 1'b0;
            sec_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            min_ones  <= 4'd0;
            min_tens  <= 4'd0;
            counting  <= 1'b0;
`ifdef MICROWAVE_DONE_PULSE_EN
            done_arm  <= 1'b0;
            done      <= 1'b0;
`endif
        end else begin
            loadn_q   <= loadn;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pgt_1Hz};
            tick_prev <= sync_q[SYNC_STAGES-1];
`ifdef MICROWAVE_DONE_PULSE_EN
            done_arm  <= 1'b0;
            done      <= done_arm;
`endif
            case (state)
                ENTRY: begin
                    sec_ones <= ld_sec_ones;
                    sec_tens <= ld_sec_tens;
                    min_ones <= ld_min_ones;
                    min_tens <= ld_min_tens;
                    if (!enablen && !ld_zero) begin
                        state    <= RUN;
                        counting <= 1'b1;
                    end
                end
                RUN: begin
                    if (enablen) begin
                        state    <= ENTRY;
                        counting <= 1'b0;
                    end else if (tick) begin
                        sec_ones <= dec_sec_ones;
                        sec_tens <= dec_sec_tens;
                        min_ones <= dec_min_ones;
                        min_tens <= dec_min_tens;
                        if (dec_zero) begin
                            state    <= DONE;
                            counting <= 1'b0;
`ifdef MICROWAVE_DONE_PULSE_EN
                            done_arm <= 1'b1;
`endif
                        end
                    end
                end
                DONE: begin
                    if (enablen) begin
                        state <= ENTRY;
                    end
                end
                default: begin
                    state    <= ENTRY;
                    counting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_microwave_countdown_timer
//
// Directed self-checking bench for microwave_countdown_timer. Covers digit
// entry, invalid digits, countdown with borrows, expiry, pause/resume and an
// asynchronous reset in the middle of a run. Time values are compared as a
// packed 16-bit {min_tens, min_ones, sec_tens, sec_ones} word.
// ---------------------------------------------------------------------------
module tb_microwave_countdown_timer;

    localparam int SYNC = 2;

    logic       clk;
    logic       clearn;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       enablen;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       zero;
    logic       counting;
`ifdef MICROWAVE_DONE_PULSE_EN
    logic       done;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    microwave_countdown_timer #(
        .SYNC_STAGES  (SYNC),
        .SEC_TENS_WRAP(4'd5)
    ) dut (
        .clk     (clk),
        .clearn  (clearn),
        .D       (D),
        .loadn   (loadn),
        .pgt_1Hz (pgt_1Hz),
        .enablen (enablen),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .min_tens(min_tens),
        .zero    (zero),
        .counting(counting)
`ifdef MICROWAVE_DONE_PULSE_EN
        ,
        .done    (done)
`endif
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] time_now();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // One comparison: count it, assert it, report on failure
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance n clock edges, ending 1 ns after the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One key press: strobe held low for 10 cycles, then released
    task automatic applyStimulus(input logic [3:0] digit);
        D     = digit;
        loadn = 1'b0;
        step(10);
        loadn = 1'b1;
        step(1);
    endtask

    // One pgt_1Hz pulse, returned low long enough to clear the synchroniser
    task automatic tick_pulse();
        pgt_1Hz = 1'b1;
        step(SYNC + 1);
        pgt_1Hz = 1'b0;
        step(SYNC + 2);
    endtask

    // Reset pulse released between clock edges
    task automatic do_reset();
        enablen = 1'b1;
        loadn   = 1'b1;
        pgt_1Hz = 1'b0;
        clearn  = 1'b0;
        #2;
        clearn  = 1'b1;
        step(1);
    endtask

    initial begin
        clearn  = 1'b0;
        D       = 4'd0;
        loadn   = 1'b1;
        pgt_1Hz = 1'b0;
        enablen = 1'b1;
        step(2);
        checkOutput("reset_time",     time_now(), 16'h0000);
        checkOutput("reset_zero",     {15'd0, zero}, 16'd1);
        checkOutput("reset_counting", {15'd0, counting}, 16'd0);
        clearn = 1'b1;
        step(1);

        // Entry: shift digits in microwave-style, holding keys down
        applyStimulus(4'd1);
        checkOutput("entry_1", time_now(), 16'h0001);
        applyStimulus(4'd2);
        checkOutput("entry_2", time_now(), 16'h0012);
        applyStimulus(4'd3);
        checkOutput("entry_3", time_now(), 16'h0123);
        applyStimulus(4'd4);
        checkOutput("entry_4", time_now(), 16'h1234);
        checkOutput("entry_zero", {15'd0, zero}, 16'd0);
        applyStimulus(4'd5);
        checkOutput("entry_5", time_now(), 16'h2345);

        // Invalid digit ignored
        do_reset();
        applyStimulus(4'd7);
        checkOutput("invalid_pre", time_now(), 16'h0007);
        applyStimulus(4'hC);
        checkOutput("invalid_digit", time_now(), 16'h0007);

        // Countdown with borrow from minutes, checking synchroniser latency
        do_reset();
        applyStimulus(4'd1);
        applyStimulus(4'd0);
        applyStimulus(4'd0);
        checkOutput("cd_loaded", time_now(), 16'h0100);
        enablen = 1'b0;
        step(1);
        checkOutput("cd_counting", {15'd0, counting}, 16'd1);
        pgt_1Hz = 1'b1;
        step(SYNC);
        checkOutput("cd_latency_hold", time_now(), 16'h0100);
        step(1);
        checkOutput("cd_borrow", time_now(), 16'h0059);
        step(3);
        checkOutput("cd_one_per_edge", time_now(), 16'h0059);
        pgt_1Hz = 1'b0;
        step(SYNC + 2);
        pgt_1Hz = 1'b1;
        step(SYNC);
        checkOutput("cd_latency_hold2", time_now(), 16'h0059);
        step(1);
        checkOutput("cd_second", time_now(), 16'h0058);
        pgt_1Hz = 1'b0;
        step(SYNC + 2);

        // Expiry
        do_reset();
        applyStimulus(4'd2);
        enablen = 1'b0;
        step(1);
        tick_pulse();
        checkOutput("exp_first", time_now(), 16'h0001);
        pgt_1Hz = 1'b1;
        step(SYNC + 1);
        checkOutput("exp_time",     time_now(), 16'h0000);
        checkOutput("exp_zero",     {15'd0, zero}, 16'd1);
        checkOutput("exp_counting", {15'd0, counting}, 16'd0);
`ifdef MICROWAVE_DONE_PULSE_EN
        checkOutput("done_before", {15'd0, done}, 16'd0);
        step(1);
        checkOutput("done_pulse", {15'd0, done}, 16'd1);
        step(1);
        checkOutput("done_after", {15'd0, done}, 16'd0);
`endif
        pgt_1Hz = 1'b0;
        step(SYNC + 2);
        tick_pulse();
        applyStimulus(4'd9);
        checkOutput("exp_hold_time",     time_now(), 16'h0000);
        checkOutput("exp_hold_counting", {15'd0, counting}, 16'd0);

        // Pause and resume with an over-59 seconds entry
        do_reset();
        applyStimulus(4'd9);
        applyStimulus(4'd0);
        enablen = 1'b0;
        step(1);
        tick_pulse();
        tick_pulse();
        tick_pulse();
        checkOutput("pause_run3", time_now(), 16'h0087);
        enablen = 1'b1;
        step(1);
        checkOutput("pause_counting", {15'd0, counting}, 16'd0);
        tick_pulse();
        checkOutput("pause_tick_ignored", time_now(), 16'h0087);
        applyStimulus(4'd1);
        checkOutput("pause_load", time_now(), 16'h0871);
        enablen = 1'b0;
        step(1);
        checkOutput("resume_counting", {15'd0, counting}, 16'd1);
        tick_pulse();
        checkOutput("resume_tick", time_now(), 16'h0870);

        // Asynchronous reset in the middle of a run
        do_reset();
        applyStimulus(4'd5);
        applyStimulus(4'd3);
        applyStimulus(4'd0);
        enablen = 1'b0;
        step(1);
        checkOutput("mid_counting_pre", {15'd0, counting}, 16'd1);
        #3;
        clearn = 1'b0;
        #1;
        checkOutput("mid_reset_time",     time_now(), 16'h0000);
        checkOutput("mid_reset_zero",     {15'd0, zero}, 16'd1);
        checkOutput("mid_reset_counting", {15'd0, counting}, 16'd0);
        clearn = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/microwave_countdown_timer.md
Name: microwave_countdown_timer

Overview:
- Four-digit BCD MM:SS countdown register for the microwave controller.
- Sits directly downstream of the keypad encoder/timer-input stage.
- Takes the encoder's BCD digit D, its active-low load strobe loadn and its 1 Hz pulse train pgt_1Hz; shifts entered digits in microwave-style, then counts down once per second while enabled.
- Feeds the display drivers and the magnetron/door control logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops synchronising pgt_1Hz into the clk domain (legal 2..3).
- SEC_TENS_WRAP, 5, value loaded into sec_tens on a borrow from minutes.

Ports:
- clk  input  1  system clock
- clearn  input  1  asynchronous active-low reset
- D  input  4  BCD digit from encoder
- loadn  input  1  active-low digit-valid strobe from encoder, held low while a key is held
- pgt_1Hz  input  1  1 Hz pulse train from encoder, asynchronous to clk
- enablen  input  1  0 = run countdown, 1 = entry/pause
- sec_ones  output  4  BCD seconds units
- sec_tens  output  4  BCD seconds tens
- min_ones  output  4  BCD minutes units
- min_tens  output  4  BCD minutes tens
- zero  output  1  1 when all four digits are 0 (combinational from digit registers)
- counting  output  1  1 while FSM is in RUN

Behaviour:
- Reset (clearn=0, asynchronous): all digits 0, FSM=ENTRY, counting=0, zero=1, synchroniser and edge-detect flops cleared (loadn history = 1).
- Load detect:
  - loadn registered once (loadn_q).
  - A load event is a cycle where loadn=0 and loadn_q=1, i.e. one event per key press regardless of hold length.
  - The shift takes effect at that same clk edge.
- Tick detect:
  - pgt_1Hz passes through SYNC_STAGES flops, then rising-edge detect.
  - Exactly one decrement per pgt_1Hz rising edge; latency SYNC_STAGES+1 clk edges.
- FSM:
  - ENTRY:
    - On a load event with D<=9: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. The old min_tens is discarded.
    - D>9: load ignored.
    - enablen=0 and zero=0 -> RUN.
    - enablen=0 and zero=1 -> stay in ENTRY.
  - RUN:
    - Loads ignored.
    - enablen=1 -> ENTRY with digits preserved (pause).
    - Otherwise each tick decrements the time.
    - A decrement that reaches 00:00 -> DONE on the same edge.
  - DONE:
    - Digits stay at 0; loads and ticks ignored.
    - enablen=1 -> ENTRY.
- Decrement arithmetic (BCD borrow chain):
  - sec_ones>0: sec_ones-1.
  - Else sec_ones=9 and borrow into sec_tens.
  - sec_tens>0: sec_tens-1.
  - Else sec_tens=SEC_TENS_WRAP and borrow into minutes.
  - Minutes decrement as a two-digit BCD count (min_ones 0 -> 9 with borrow from min_tens).
  - Entered seconds above 59 (e.g. 00:90) are legal and count 90, 89, ... down to 00.
  - No decrement ever occurs at 00:00, so no underflow is possible.
- Simultaneous events:
  - Tick and enablen rising in the same cycle: the transition to ENTRY wins and the tick is dropped.
  - Load event in the same cycle as enablen falling: the load applies and the FSM enters RUN with the new value, if nonzero.
- clearn asserted mid-count: immediate clear to the reset state. A pgt_1Hz edge pending in the synchroniser is lost.

Optional Feature:
- Macro: MICROWAVE_DONE_PULSE_EN.
- Defined:
  - Adds output port done (1 bit), reset 0.
  - done pulses high for exactly one clk cycle on the edge after the RUN -> DONE transition.
  - Reaching zero only by reset or through pause/entry never pulses done.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Entry:
  - Reset, enablen=1.
  - Load D=1,2,3,4 (each with loadn held low 10 cycles, then high).
  - Expect 12:34 after 4 presses; holding loadn does not repeat digits.
  - A 5th press with D=5 gives 23:45.
- Invalid digit: at 00:07, a load with D=4'hC leaves 00:07 unchanged.
- Countdown with borrow:
  - Enter 01:00, drop enablen, apply 2 pgt_1Hz edges.
  - Expect counting=1, then 00:59, then 00:58; each change occurs SYNC_STAGES+1 cycles after the pgt_1Hz rise.
- Expiry:
  - Enter 00:02, run 2 ticks.
  - Expect 00:00, zero=1, counting=0, FSM DONE.
  - Further ticks and loads cause no change.
  - With MICROWAVE_DONE_PULSE_EN, done is high for exactly 1 cycle.
- Pause and resume:
  - Run 00:90 for 3 ticks, giving 00:87.
  - Raise enablen: counting=0, ticks ignored.
  - A load with D=1 gives 08:71.
  - Lower enablen: counting resumes from 08:71.
- Reset mid-run: assert clearn asynchronously (between clk edges) while at 05:30 in RUN. Outputs immediately read 00:00, zero=1, counting=0.
